// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station: op table, ROB tag range,
// default depth and broadcast bus field widths.
package alu_rs_pkg;

  localparam int RS_SIZE_DEFAULT = 16;
  localparam int ENTRY_RANGE_W   = 4;
  localparam int DATA_W          = 32;
  localparam int OP_W            = 6;

  typedef logic [ENTRY_RANGE_W-1:0] entry_range_t;

  typedef enum logic [OP_W-1:0] {
    OP_LUI   = 6'd0,
    OP_AUIPC = 6'd1,
    OP_JAL   = 6'd2,
    OP_JALR  = 6'd3,
    OP_BEQ   = 6'd4,
    OP_BNE   = 6'd5,
    OP_BLT   = 6'd6,
    OP_BGE   = 6'd7,
    OP_BLTU  = 6'd8,
    OP_BGEU  = 6'd9,
    OP_ADDI  = 6'd18,
    OP_SLTI  = 6'd19,
    OP_XORI  = 6'd21,
    OP_ORI   = 6'd22,
    OP_ANDI  = 6'd23,
    OP_ADD   = 6'd27,
    OP_SUB   = 6'd28,
    OP_SLT   = 6'd30,
    OP_XOR   = 6'd32,
    OP_OR    = 6'd35,
    OP_AND   = 6'd36
  } alu_op_e;

endpackage

// File: rtl/alu_rs_select.sv
// Combinational slot picker for alu_rs: lowest free slot and the slot to issue.
// With RS_AGE_ORDER_EN defined the oldest ready slot (smallest rank) is chosen.
module rs_select import alu_rs_pkg::*; #(
  parameter int RS_SIZE = RS_SIZE_DEFAULT,
  parameter int IDX_W   = $clog2(RS_SIZE)
) (
  input  logic [RS_SIZE-1:0]            busy,
  input  logic [RS_SIZE-1:0]            ready,
`ifdef RS_AGE_ORDER_EN
  input  logic [RS_SIZE-1:0][IDX_W-1:0] rank,
`endif
  output logic [IDX_W-1:0]              free_idx,
  output logic                          free_valid,
  output logic [IDX_W-1:0]              issue_idx,
  output logic                          issue_valid
);

  always_comb begin
    free_idx   = '0;
    free_valid = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_idx   = IDX_W'(i);
        free_valid = 1'b1;
      end
    end
  end

`ifdef RS_AGE_ORDER_EN
  logic [IDX_W-1:0] best_rank;

  always_comb begin
    issue_idx   = '0;
    issue_valid = 1'b0;
    best_rank   = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ready[i] && (!issue_valid || rank[i] < best_rank)) begin
        issue_idx   = IDX_W'(i);
        issue_valid = 1'b1;
        best_rank   = rank[i];
      end
    end
  end
`else
  always_comb begin
    issue_idx   = '0;
    issue_valid = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        issue_idx   = IDX_W'(i);
        issue_valid = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands are valid,
// snoops the ALU/LSB buses and issues one ready entry per cycle. Optional RS_AGE_ORDER_EN.
module alu_rs import alu_rs_pkg::*; #(
  parameter int RS_SIZE = RS_SIZE_DEFAULT,
  parameter int ENTRY_W = ENTRY_RANGE_W
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               flush,
  input  logic               dsp_valid,
  input  logic [OP_W-1:0]    dsp_op,
  input  logic [DATA_W-1:0]  dsp_instruction,
  input  logic [DATA_W-1:0]  dsp_pc,
  input  logic [DATA_W-1:0]  dsp_imm,
  input  logic [DATA_W-1:0]  dsp_vj,
  input  logic [DATA_W-1:0]  dsp_vk,
  input  logic               dsp_qj_busy,
  input  logic               dsp_qk_busy,
  input  logic [ENTRY_W-1:0] dsp_qj,
  input  logic [ENTRY_W-1:0] dsp_qk,
  input  logic [ENTRY_W-1:0] dsp_entry,
  output logic               rs_full,
  input  logic               alu_broadcast,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic [ENTRY_W-1:0] alu_entry,
  input  logic               lsb_broadcast,
  input  logic [DATA_W-1:0]  lsb_result,
  input  logic [ENTRY_W-1:0] lsb_entry,
  output logic               new_calculate,
  output logic [OP_W-1:0]    op,
  output logic [DATA_W-1:0]  instruction,
  output logic [DATA_W-1:0]  vj,
  output logic [DATA_W-1:0]  vk,
  output logic [DATA_W-1:0]  pc,
  output logic [DATA_W-1:0]  imm,
  output logic [ENTRY_W-1:0] entry
);

  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] busy, qj_busy, qk_busy, ready;
  logic [OP_W-1:0]    s_op          [RS_SIZE];
  logic [DATA_W-1:0]  s_instruction [RS_SIZE];
  logic [DATA_W-1:0]  s_pc          [RS_SIZE];
  logic [DATA_W-1:0]  s_imm         [RS_SIZE];
  logic [DATA_W-1:0]  s_vj          [RS_SIZE];
  logic [DATA_W-1:0]  s_vk          [RS_SIZE];
  logic [ENTRY_W-1:0] s_qj          [RS_SIZE];
  logic [ENTRY_W-1:0] s_qk          [RS_SIZE];
  logic [ENTRY_W-1:0] s_entry       [RS_SIZE];

  logic [IDX_W-1:0]  free_idx, issue_idx;
  logic              free_valid, issue_valid, do_dispatch;
  logic [DATA_W-1:0] fwd_vj, fwd_vk;
  logic              fwd_qj_busy, fwd_qk_busy;

  assign ready       = busy & ~qj_busy & ~qk_busy;
  assign rs_full     = &busy;
  assign do_dispatch = dsp_valid && free_valid;

`ifdef RS_AGE_ORDER_EN
  logic [RS_SIZE-1:0][IDX_W-1:0] rank;
  logic [IDX_W:0]                busy_count;
  logic [IDX_W-1:0]              new_rank;

  always_comb begin
    busy_count = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_count = busy_count + (IDX_W+1)'(busy[i]);
    end
    new_rank = IDX_W'(busy_count - (IDX_W+1)'(issue_valid));
  end

  // Rank 0 is the oldest; an issue closes the gap so ranks stay dense.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rank <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        rank <= '0;
      end else begin
        if (issue_valid) begin
          for (int i = 0; i < RS_SIZE; i++) begin
            if (busy[i] && rank[i] > rank[issue_idx]) rank[i] <= rank[i] - IDX_W'(1);
          end
        end
        if (do_dispatch) rank[free_idx] <= new_rank;
      end
    end
  end
`endif

  rs_select #(.RS_SIZE(RS_SIZE), .IDX_W(IDX_W)) u_select (
    .busy        (busy),
    .ready       (ready),
`ifdef RS_AGE_ORDER_EN
    .rank        (rank),
`endif
    .free_idx    (free_idx),
    .free_valid  (free_valid),
    .issue_idx   (issue_idx),
    .issue_valid (issue_valid)
  );

  // Same-cycle bypass for dispatch operands; the ALU bus takes precedence.
  always_comb begin
    fwd_vj      = dsp_vj;
    fwd_qj_busy = dsp_qj_busy;
    fwd_vk      = dsp_vk;
    fwd_qk_busy = dsp_qk_busy;
    if (dsp_qj_busy) begin
      if (alu_broadcast && alu_entry == dsp_qj) begin
        fwd_vj      = alu_result;
        fwd_qj_busy = 1'b0;
      end else if (lsb_broadcast && lsb_entry == dsp_qj) begin
        fwd_vj      = lsb_result;
        fwd_qj_busy = 1'b0;
      end
    end
    if (dsp_qk_busy) begin
      if (alu_broadcast && alu_entry == dsp_qk) begin
        fwd_vk      = alu_result;
        fwd_qk_busy = 1'b0;
      end else if (lsb_broadcast && lsb_entry == dsp_qk) begin
        fwd_vk      = lsb_result;
        fwd_qk_busy = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy          <= '0;
      qj_busy       <= '0;
      qk_busy       <= '0;
      new_calculate <= 1'b0;
      op            <= '0;
      instruction   <= '0;
      vj            <= '0;
      vk            <= '0;
      pc            <= '0;
      imm           <= '0;
      entry         <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        s_op[i]          <= '0;
        s_instruction[i] <= '0;
        s_pc[i]          <= '0;
        s_imm[i]         <= '0;
        s_vj[i]          <= '0;
        s_vk[i]          <= '0;
        s_qj[i]          <= '0;
        s_qk[i]          <= '0;
        s_entry[i]       <= '0;
      end
    end else if (rdy_in) begin
      if (flush) begin
        busy          <= '0;
        new_calculate <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i] && qj_busy[i]) begin
            if (alu_broadcast && alu_entry == s_qj[i]) begin
              s_vj[i]    <= alu_result;
              qj_busy[i] <= 1'b0;
            end else if (lsb_broadcast && lsb_entry == s_qj[i]) begin
              s_vj[i]    <= lsb_result;
              qj_busy[i] <= 1'b0;
            end
          end
          if (busy[i] && qk_busy[i]) begin
            if (alu_broadcast && alu_entry == s_qk[i]) begin
              s_vk[i]    <= alu_result;
              qk_busy[i] <= 1'b0;
            end else if (lsb_broadcast && lsb_entry == s_qk[i]) begin
              s_vk[i]    <= lsb_result;
              qk_busy[i] <= 1'b0;
            end
          end
        end

        new_calculate <= issue_valid;
        if (issue_valid) begin
          busy[issue_idx] <= 1'b0;
          op              <= s_op[issue_idx];
          instruction     <= s_instruction[issue_idx];
          vj              <= s_vj[issue_idx];
          vk              <= s_vk[issue_idx];
          pc              <= s_pc[issue_idx];
          imm             <= s_imm[issue_idx];
          entry           <= s_entry[issue_idx];
        end

        if (do_dispatch) begin
          busy[free_idx]          <= 1'b1;
          s_op[free_idx]          <= dsp_op;
          s_instruction[free_idx] <= dsp_instruction;
          s_pc[free_idx]          <= dsp_pc;
          s_imm[free_idx]         <= dsp_imm;
          s_vj[free_idx]          <= fwd_vj;
          s_vk[free_idx]          <= fwd_vk;
          qj_busy[free_idx]       <= fwd_qj_busy;
          qk_busy[free_idx]       <= fwd_qk_busy;
          s_qj[free_idx]          <= dsp_qj;
          s_qk[free_idx]          <= dsp_qk;
          s_entry[free_idx]       <= dsp_entry;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for alu_rs; expectations are hand-computed.
// Issue-order expectations follow RS_AGE_ORDER_EN when it is defined.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        flush = 1'b0;
  logic        dsp_valid = 1'b0;
  logic [5:0]  dsp_op = '0;
  logic [31:0] dsp_instruction = '0, dsp_pc = '0, dsp_imm = '0, dsp_vj = '0, dsp_vk = '0;
  logic        dsp_qj_busy = 1'b0, dsp_qk_busy = 1'b0;
  logic [3:0]  dsp_qj = '0, dsp_qk = '0, dsp_entry = '0;
  logic        rs_full;
  logic        alu_broadcast = 1'b0, lsb_broadcast = 1'b0;
  logic [31:0] alu_result = '0, lsb_result = '0;
  logic [3:0]  alu_entry = '0, lsb_entry = '0;
  logic        new_calculate;
  logic [5:0]  op;
  logic [31:0] instruction, vj, vk, pc, imm;
  logic [3:0]  entry;

  int checkCount = 0;
  int errorCount = 0;

  alu_rs #(.RS_SIZE(16), .ENTRY_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .dsp_valid(dsp_valid), .dsp_op(dsp_op), .dsp_instruction(dsp_instruction),
    .dsp_pc(dsp_pc), .dsp_imm(dsp_imm), .dsp_vj(dsp_vj), .dsp_vk(dsp_vk),
    .dsp_qj_busy(dsp_qj_busy), .dsp_qk_busy(dsp_qk_busy), .dsp_qj(dsp_qj),
    .dsp_qk(dsp_qk), .dsp_entry(dsp_entry), .rs_full(rs_full),
    .alu_broadcast(alu_broadcast), .alu_result(alu_result), .alu_entry(alu_entry),
    .lsb_broadcast(lsb_broadcast), .lsb_result(lsb_result), .lsb_entry(lsb_entry),
    .new_calculate(new_calculate), .op(op), .instruction(instruction),
    .vj(vj), .vk(vk), .pc(pc), .imm(imm), .entry(entry)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] opc, input logic [31:0] vjVal, input logic qjBusy,
                               input logic [3:0] qjTag, input logic [31:0] vkVal, input logic qkBusy,
                               input logic [3:0] qkTag, input logic [31:0] immVal, input logic [3:0] ent);
    dsp_valid       = 1'b1;
    dsp_op          = opc;
    dsp_vj          = vjVal;
    dsp_qj_busy     = qjBusy;
    dsp_qj          = qjTag;
    dsp_vk          = vkVal;
    dsp_qk_busy     = qkBusy;
    dsp_qk          = qkTag;
    dsp_imm         = immVal;
    dsp_entry       = ent;
    dsp_pc          = 32'h0000_1000 + {26'd0, ent, 2'b00};
    dsp_instruction = 32'hA000_0000 | {28'd0, ent};
  endtask

  task automatic clearInputs();
    dsp_valid     = 1'b0;
    alu_broadcast = 1'b0;
    lsb_broadcast = 1'b0;
    flush         = 1'b0;
  endtask

  initial begin
    logic [31:0] firstEntry, secondEntry;

    // Reset values
    #12;
    checkOutput("rst_nc", 32'(new_calculate), 32'd0);
    checkOutput("rst_op", 32'(op), 32'd0);
    checkOutput("rst_vj", vj, 32'd0);
    checkOutput("rst_vk", vk, 32'd0);
    checkOutput("rst_pc", pc, 32'd0);
    checkOutput("rst_imm", imm, 32'd0);
    checkOutput("rst_instr", instruction, 32'd0);
    checkOutput("rst_entry", 32'(entry), 32'd0);
    checkOutput("rst_full", 32'(rs_full), 32'd0);
    rst_in = 1'b0;

    // Ready ADDI: issue visible only in the cycle after dispatch
    applyStimulus(OP_ADDI, 32'd5, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd7, 4'd1);
    tick();
    clearInputs();
    checkOutput("addi_no_same_edge", 32'(new_calculate), 32'd0);
    tick();
    checkOutput("addi_nc", 32'(new_calculate), 32'd1);
    checkOutput("addi_op", 32'(op), 32'(OP_ADDI));
    checkOutput("addi_vj", vj, 32'd5);
    checkOutput("addi_imm", imm, 32'd7);
    checkOutput("addi_entry", 32'(entry), 32'd1);
    checkOutput("addi_pc", pc, 32'h0000_1004);
    tick();
    checkOutput("addi_one_cycle", 32'(new_calculate), 32'd0);

    // ADD waits for qj=3 from the ALU bus
    applyStimulus(OP_ADD, 32'd0, 1'b1, 4'd3, 32'd2, 1'b0, 4'd0, 32'd0, 4'd2);
    tick();
    clearInputs();
    checkOutput("add_pending", 32'(new_calculate), 32'd0);
    alu_broadcast = 1'b1; alu_entry = 4'd3; alu_result = 32'd10;
    tick();
    clearInputs();
    checkOutput("add_no_wake_issue", 32'(new_calculate), 32'd0);
    tick();
    checkOutput("add_nc", 32'(new_calculate), 32'd1);
    checkOutput("add_op", 32'(op), 32'(OP_ADD));
    checkOutput("add_vj", vj, 32'd10);
    checkOutput("add_vk", vk, 32'd2);
    checkOutput("add_entry", 32'(entry), 32'd2);
    tick();

    // LSB result captured in the dispatch cycle
    applyStimulus(OP_SUB, 32'd1, 1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'd0, 4'd3);
    lsb_broadcast = 1'b1; lsb_entry = 4'd6; lsb_result = 32'hFFFF_FFFF;
    tick();
    clearInputs();
    tick();
    checkOutput("lsb_fwd_nc", 32'(new_calculate), 32'd1);
    checkOutput("lsb_fwd_vk", vk, 32'hFFFF_FFFF);
    checkOutput("lsb_fwd_entry", 32'(entry), 32'd3);
    tick();

    // Both buses carry the same tag at dispatch: ALU wins
    applyStimulus(OP_XOR, 32'd0, 1'b1, 4'd5, 32'd4, 1'b0, 4'd0, 32'd0, 4'd4);
    alu_broadcast = 1'b1; alu_entry = 4'd5; alu_result = 32'h11;
    lsb_broadcast = 1'b1; lsb_entry = 4'd5; lsb_result = 32'h22;
    tick();
    clearInputs();
    tick();
    checkOutput("alu_wins_nc", 32'(new_calculate), 32'd1);
    checkOutput("alu_wins_vj", vj, 32'h11);
    tick();

    // Fill all 16 slots, slot i waits on tag i
    for (int i = 0; i < 16; i++) begin
      applyStimulus(OP_AND, 32'd0, 1'b1, 4'(i), 32'(100 + i), 1'b0, 4'd0, 32'd0, 4'(i));
      tick();
      if (i == 14) checkOutput("full_at_15", 32'(rs_full), 32'd0);
    end
    clearInputs();
    checkOutput("full_at_16", 32'(rs_full), 32'd1);
    applyStimulus(OP_OR, 32'd55, 1'b0, 4'd0, 32'd66, 1'b0, 4'd0, 32'd0, 4'd15);
    tick();
    clearInputs();
    checkOutput("overflow_full", 32'(rs_full), 32'd1);
    tick();
    checkOutput("overflow_ignored", 32'(new_calculate), 32'd0);
    alu_broadcast = 1'b1; alu_entry = 4'd0; alu_result = 32'h77;
    tick();
    clearInputs();
    checkOutput("wake_still_full", 32'(rs_full), 32'd1);
    tick();
    checkOutput("full_issue_nc", 32'(new_calculate), 32'd1);
    checkOutput("full_issue_entry", 32'(entry), 32'd0);
    checkOutput("full_issue_vj", vj, 32'h77);
    checkOutput("full_issue_vk", vk, 32'd100);
    checkOutput("full_issue_op", 32'(op), 32'(OP_AND));
    checkOutput("full_cleared", 32'(rs_full), 32'd0);
    tick();

    // Flush clears the leftover 15, then flush races a dispatch and a ready issue
    flush = 1'b1;
    tick();
    clearInputs();
    checkOutput("flush1_full", 32'(rs_full), 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(OP_ADD, 32'd0, (i != 3), 4'(i + 1), 32'd0, 1'b0, 4'd0, 32'd0, 4'(i + 8));
      tick();
    end
    flush = 1'b1;
    applyStimulus(OP_ADDI, 32'd1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd12);
    tick();
    clearInputs();
    checkOutput("flush2_nc", 32'(new_calculate), 32'd0);
    checkOutput("flush2_full", 32'(rs_full), 32'd0);
    alu_broadcast = 1'b1; alu_entry = 4'd1; alu_result = 32'd1;
    lsb_broadcast = 1'b1; lsb_entry = 4'd2; lsb_result = 32'd2;
    tick();
    clearInputs();
    tick();
    checkOutput("flush2_empty", 32'(new_calculate), 32'd0);

    // Issue order: slot 5 older than re-dispatched slot 2
    for (int i = 0; i < 6; i++) begin
      applyStimulus(OP_ADD, 32'd0, 1'b1, 4'(10 + i), 32'd0, 1'b0, 4'd0, 32'd0, 4'(i));
      tick();
    end
    clearInputs();
    alu_broadcast = 1'b1; alu_entry = 4'd12; alu_result = 32'd3;
    tick();
    clearInputs();
    tick();
    checkOutput("age_prep_entry", 32'(entry), 32'd2);
    applyStimulus(OP_SUB, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd9, 32'd0, 4'd12);
    tick();
    clearInputs();
    alu_broadcast = 1'b1; alu_entry = 4'd15; alu_result = 32'd5;
    lsb_broadcast = 1'b1; lsb_entry = 4'd9; lsb_result = 32'd9;
    tick();
    clearInputs();
`ifdef RS_AGE_ORDER_EN
    firstEntry = 32'd5; secondEntry = 32'd12;
`else
    firstEntry = 32'd12; secondEntry = 32'd5;
`endif
    tick();
    checkOutput("order_first_nc", 32'(new_calculate), 32'd1);
    checkOutput("order_first", 32'(entry), firstEntry);
    tick();
    checkOutput("order_second_nc", 32'(new_calculate), 32'd1);
    checkOutput("order_second", 32'(entry), secondEntry);

    // Mid-run asynchronous reset discards everything immediately
    alu_broadcast = 1'b1; alu_entry = 4'd11; alu_result = 32'd6;
    tick();
    clearInputs();
    tick();
    checkOutput("pre_reset_entry", 32'(entry), 32'd1);
    rst_in = 1'b1;
    #1;
    checkOutput("async_rst_nc", 32'(new_calculate), 32'd0);
    checkOutput("async_rst_entry", 32'(entry), 32'd0);
    checkOutput("async_rst_op", 32'(op), 32'd0);
    rst_in = 1'b0;
    alu_broadcast = 1'b1; alu_entry = 4'd13; alu_result = 32'd1;
    lsb_broadcast = 1'b1; lsb_entry = 4'd14; lsb_result = 32'd1;
    tick();
    clearInputs();
    tick();
    checkOutput("rst_discarded", 32'(new_calculate), 32'd0);

    // rdy_in low freezes outputs and ignores dispatch
    applyStimulus(OP_ADDI, 32'd9, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd3, 4'd7);
    tick();
    clearInputs();
    tick();
    checkOutput("pause_pre_nc", 32'(new_calculate), 32'd1);
    rdy_in = 1'b0;
    applyStimulus(OP_OR, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd0, 4'd8);
    tick();
    checkOutput("pause_hold_nc", 32'(new_calculate), 32'd1);
    checkOutput("pause_hold_entry", 32'(entry), 32'd7);
    tick();
    checkOutput("pause_hold_nc2", 32'(new_calculate), 32'd1);
    clearInputs();
    rdy_in = 1'b1;
    tick();
    checkOutput("resume_nc", 32'(new_calculate), 32'd0);
    tick();
    checkOutput("paused_dsp_dropped", 32'(new_calculate), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
